regfile_writer: RTL and testbench
=================================

REGFILE_WRITER -- requirements
Module: regfile_writer

Interface
REQ-001 Parameter: WIDTH, 32, data width of each register.
REQ-002 Parameter: ZERO_R0, 1, when 1 register 0 reads as zero and ignores writes.
REQ-003 Clocking and reset SHALL be one clock and an asynchronous, active-low reset, on ports clk and rst_n.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 wr_valid  input  1  write request present.
REQ-007 wr_ready  output  1  block can accept a write this cycle.
REQ-008 wr_addr  input  5  target register index 0..31.
REQ-009 wr_data  input  WIDTH  write data.
REQ-010 wr_be  input  WIDTH/8  byte enables, bit i covers data[8i+7:8i].
REQ-011 wr_ack  output  1  one-cycle pulse, previous-cycle write committed.
REQ-012 clear_req  input  1  request to zero all registers.
REQ-013 clear_busy  output  1  clear sequence in progress.
REQ-014 clear_done  output  1  one-cycle pulse, clear sequence finished.
REQ-015 regs_out  output  32*WIDTH  flattened register contents, register k at [k*WIDTH +: WIDTH], feeding the 32-to-1 read mux.

Function
REQ-016 A write SHALL be accepted on a rising edge where wr_valid and wr_ready are both 1.
REQ-017 An accepted write SHALL update only the addressed register's enabled bytes at that edge, visible on regs_out the next cycle.
REQ-018 wr_ack SHALL be 1 for exactly the cycle after each accepted write, else 0.
REQ-019 wr_be = 0 SHALL still count as accepted and acked, with no data change.
REQ-020 With ZERO_R0=1, writes to address 0 SHALL be accepted and acked, but register 0 SHALL remain 0.
REQ-021 The FSM SHALL have exactly two states: IDLE and CLEAR.
REQ-022 wr_ready SHALL be 1 in IDLE and 0 in CLEAR; it SHALL be a registered-state decode only.
REQ-023 IDLE->CLEAR SHALL occur on an edge with clear_req=1 in IDLE; the 5-bit clear counter SHALL load 0.
REQ-024 If clear_req and an accepted write coincide in IDLE, the write SHALL commit and be acked, and the clear SHALL start next cycle.
REQ-025 In CLEAR, each edge SHALL zero register[counter] and then increment the counter.
REQ-026 The clear sequence SHALL take 32 cycles, covering index 0..31 in ascending order.
REQ-027 On the edge clearing index 31: CLEAR->IDLE, the counter SHALL wrap to 0, and clear_done SHALL pulse in the following cycle.
REQ-028 clear_busy SHALL equal (state == CLEAR).
REQ-029 clear_req asserted while in CLEAR SHALL be ignored (no restart, no queueing).
REQ-030 clear_req held high through the clear_done cycle SHALL start a new clear from IDLE.
REQ-031 wr_valid may be held during CLEAR; it SHALL be accepted on the first IDLE cycle.
REQ-032 Registers SHALL change only on accepted writes, clear steps or reset.

Reset
REQ-033 On rst_n=0, asynchronously: all registers = 0, state = IDLE, counter = 0, wr_ack = 0, clear_done = 0.
REQ-034 Reset asserted mid-clear SHALL abort the sequence, with no clear_done pulse.
REQ-035 Reset asserted in the cycle after an accepted write SHALL suppress that write's wr_ack.
REQ-036 Outputs after reset release SHALL be: wr_ready = 1, clear_busy = 0, regs_out = 0.

Structure
REQ-037 Shared package regfile_pkg SHALL hold NREGS=32, ADDR_W=5, WIDTH default and the IDLE/CLEAR state encoding.
REQ-038 The single sub-module SHALL be regfile_decoder5to32: 5-bit index plus enable in, 32-bit one-hot out.
REQ-039 The decoder SHALL be shared between the write address and the clear counter through a state-selected index.

Verification
REQ-040 Write 0xDEADBEEF to r5 with be=0xF -> r5 = 0xDEADBEEF next cycle, wr_ack pulses once, all other registers unchanged.
REQ-041 r7 = 0x11223344, then write 0xAABBCCDD with be=0b0101 -> r7 = 0x11BB33DD.
REQ-042 Write 0xFFFFFFFF to r0 with ZERO_R0=1 -> wr_ack = 1 and r0 = 0.
REQ-043 All registers nonzero, pulse clear_req -> clear_busy for 32 cycles, wr_ready = 0 throughout, registers zeroed in order 0..31, clear_done one pulse, regs_out all 0.
REQ-044 Same-cycle write of 0x5 to r31 and clear_req -> write acked, then r31 cleared at clear cycle 32.
REQ-045 rst_n low at clear cycle 10 -> immediate all-zero, IDLE, no clear_done; a write after release is accepted with wr_ack.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and the FSM state encoding for the register file writer.
//   NREGS         : number of registers (32)
//   ADDR_W        : register index width (5)
//   DEFAULT_WIDTH : default register data width (32)
//   state_t       : IDLE (normal write service) / CLEAR (sequential zeroing)
package regfile_pkg;

    localparam int NREGS         = 32;
    localparam int ADDR_W        = 5;
    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_decoder5to32.sv
// regfile_decoder5to32
// 5-bit index to 32-bit one-hot decoder with enable.
//   idx    : register index 0..31
//   en     : when 0 the output is all zeros
//   onehot : bit idx set when en=1
module regfile_decoder5to32
    import regfile_pkg::*;
(
    input  logic [ADDR_W-1:0] idx,
    input  logic              en,
    output logic [NREGS-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_writer.sv
// regfile_writer
// 32-entry register file write port with byte enables and a 32-cycle
// sequential clear engine.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   wr_valid     : write request present
//   wr_ready     : write can be accepted this cycle (1 in IDLE only)
//   wr_addr      : target register index
//   wr_data      : write data
//   wr_be        : byte enables, bit i covers data[8i+7:8i]
//   wr_ack       : one-cycle pulse the cycle after an accepted write
//   clear_req    : request to zero all registers (sampled in IDLE only)
//   clear_busy   : clear sequence in progress
//   clear_done   : one-cycle pulse the cycle after index 31 was cleared
//   regs_out     : flattened contents, register k at [k*WIDTH +: WIDTH]
//   state_dbg    : current FSM state
//
// Handshake: a write transfers on a rising edge where wr_valid && wr_ready;
// wr_valid may be held while wr_ready is low and the request waits unchanged.
module regfile_writer
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int ZERO_R0 = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [WIDTH/8-1:0]     wr_be,
    output logic                   wr_ack,
    input  logic                   clear_req,
    output logic                   clear_busy,
    output logic                   clear_done,
    output logic [NREGS*WIDTH-1:0] regs_out,
    output state_t                 state_dbg
);

    localparam int NB = WIDTH / 8;

    state_t                   state, state_nxt;
    logic [ADDR_W-1:0]        cnt, cnt_nxt;
    logic                     done_nxt;
    logic [NREGS*WIDTH-1:0]   regs_q;

    logic                     clearing;
    logic                     wr_fire;
    logic [ADDR_W-1:0]        dec_idx;
    logic                     dec_en;
    logic [NREGS-1:0]         sel;

    // Ready is a pure decode of the registered state.
    assign wr_ready   = (state == IDLE);
    assign clearing   = (state == CLEAR);
    assign clear_busy = clearing;
    assign wr_fire    = wr_valid && wr_ready;
    assign regs_out   = regs_q;
    assign state_dbg  = state;

    // One decoder serves both sources: the clear counter owns it in CLEAR,
    // the write address in IDLE. Writes cannot fire in CLEAR, so no conflict.
    assign dec_idx = clearing ? cnt : wr_addr;
    assign dec_en  = clearing || wr_fire;

    regfile_decoder5to32 u_dec (
        .idx    (dec_idx),
        .en     (dec_en),
        .onehot (sel)
    );

    // State register and clear counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_ack     <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wr_ack     <= wr_fire;
            clear_done <= done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                // Counter wraps 31 -> 0 naturally on the final step.
                cnt_nxt = cnt + 1'b1;
                if (cnt == ADDR_W'(NREGS - 1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Register storage. Selected register is zeroed in CLEAR (and always for
    // r0 when ZERO_R0 is set); otherwise enabled bytes take wr_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                if (sel[k]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (clearing || (ZERO_R0 != 0 && k == 0)) begin
                            regs_q[k*WIDTH + 8*b +: 8] <= 8'h00;
                        end else if (wr_be[b]) begin
                            regs_q[k*WIDTH + 8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_writer.sv
// tb_regfile_writer
// Directed self-checking bench for regfile_writer (WIDTH=32, ZERO_R0=1).
module tb_regfile_writer;
    import regfile_pkg::*;

    localparam int W = 32;

    logic              clk;
    logic              rst_n;
    logic              wr_valid;
    logic              wr_ready;
    logic [4:0]        wr_addr;
    logic [W-1:0]      wr_data;
    logic [W/8-1:0]    wr_be;
    logic              wr_ack;
    logic              clear_req;
    logic              clear_busy;
    logic              clear_done;
    logic [32*W-1:0]   regs_out;
    state_t            state_dbg;

    int                n_cmp = 0;
    int                n_err = 0;
    logic [W-1:0]      mdl [32];
    logic [W-1:0]      exp_q [$];

    regfile_writer #(.WIDTH(W), .ZERO_R0(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .wr_ack     (wr_ack),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .regs_out   (regs_out),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rd(input int k);
        return regs_out[k*W +: W];
    endfunction

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 32; k++) begin
            check_eq($sformatf("%s_r%0d", tag, k), rd(k), mdl[k]);
        end
    endtask

    task automatic model_zero();
        for (int k = 0; k < 32; k++) mdl[k] = '0;
    endtask

    // Drive one write while ready; check ack and data the next cycle.
    task automatic do_write(input logic [4:0] a, input logic [W-1:0] d, input logic [3:0] be);
        logic [W-1:0] nv;
        nv = mdl[a];
        for (int b = 0; b < 4; b++) if (be[b]) nv[8*b +: 8] = d[8*b +: 8];
        if (a == 0) nv = '0;
        exp_q.push_back(nv);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_valid = 1'b0;
        check_eq($sformatf("wr_ack_r%0d", a), {31'b0, wr_ack}, 32'd1);
        check_eq($sformatf("wr_data_r%0d", a), rd(a), exp_q.pop_front());
        mdl[a] = nv;
        tick();
        check_eq($sformatf("wr_ack_low_r%0d", a), {31'b0, wr_ack}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; clear_req = 1'b0;
        model_zero();
        #12;
        check_eq("rst_wr_ack", {31'b0, wr_ack}, 32'd0);
        check_eq("rst_clear_done", {31'b0, clear_done}, 32'd0);
        check_eq("rst_regs_zero", {31'b0, |regs_out}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("rel_wr_ready", {31'b0, wr_ready}, 32'd1);
        check_eq("rel_clear_busy", {31'b0, clear_busy}, 32'd0);
        check_eq("rel_state", {31'b0, state_dbg}, {31'b0, IDLE});

        // Full-word write to r5
        do_write(5'd5, 32'hDEADBEEF, 4'hF);
        check_eq("r5_const", rd(5), 32'hDEADBEEF);
        check_all("after_r5");

        // Byte-enable merge on r7
        do_write(5'd7, 32'h11223344, 4'hF);
        do_write(5'd7, 32'hAABBCCDD, 4'b0101);
        check_eq("r7_merge_const", rd(7), 32'h11BB33DD);

        // r0 is hard-wired to zero but still acked
        do_write(5'd0, 32'hFFFFFFFF, 4'hF);
        check_eq("r0_const", rd(0), 32'h0);

        // Zero byte enables: acked, no change
        do_write(5'd5, 32'h00000000, 4'h0);
        check_eq("r5_be0_const", rd(5), 32'hDEADBEEF);

        // Fill every register with a nonzero value
        for (int k = 1; k < 32; k++) do_write(5'(k), 32'hA500_0000 | k, 4'hF);
        check_all("filled");

        // Clear sequence with a mid-clear clear_req (ignored) and a held write
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check_eq("clr_busy_start", {31'b0, clear_busy}, 32'd1);
        check_eq("clr_ready_start", {31'b0, wr_ready}, 32'd0);
        check_eq("clr_r0_pending", rd(1), mdl[1]);
        for (int i = 0; i < 32; i++) begin
            if (i == 10) clear_req = 1'b1;
            if (i == 20) begin
                wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; wr_be = 4'hF;
            end
            tick();
            clear_req = 1'b0;
            mdl[i] = '0;
            check_eq($sformatf("clr_idx%0d", i), rd(i), 32'h0);
            check_eq($sformatf("clr_ack%0d", i), {31'b0, wr_ack}, 32'd0);
            if (i < 31) begin
                check_eq($sformatf("clr_next%0d", i), rd(i + 1), mdl[i + 1]);
                check_eq($sformatf("clr_busy%0d", i), {31'b0, clear_busy}, 32'd1);
                check_eq($sformatf("clr_ready%0d", i), {31'b0, wr_ready}, 32'd0);
                check_eq($sformatf("clr_done_early%0d", i), {31'b0, clear_done}, 32'd0);
            end else begin
                check_eq("clr_busy_end", {31'b0, clear_busy}, 32'd0);
                check_eq("clr_done_pulse", {31'b0, clear_done}, 32'd1);
                check_eq("clr_ready_end", {31'b0, wr_ready}, 32'd1);
            end
        end
        // Held write lands on the first IDLE edge
        tick();
        wr_valid = 1'b0;
        mdl[3] = 32'h33;
        check_eq("held_wr_ack", {31'b0, wr_ack}, 32'd1);
        check_eq("clr_done_gone", {31'b0, clear_done}, 32'd0);
        check_eq("clr_busy_stay_idle", {31'b0, clear_busy}, 32'd0);
        check_all("after_clear");

        // Write r31 together with clear_req: write first, r31 cleared at step 32
        wr_valid = 1'b1; wr_addr = 5'd31; wr_data = 32'h5; wr_be = 4'hF; clear_req = 1'b1;
        tick();
        wr_valid = 1'b0; clear_req = 1'b0;
        check_eq("coin_ack", {31'b0, wr_ack}, 32'd1);
        check_eq("coin_r31", rd(31), 32'h5);
        check_eq("coin_busy", {31'b0, clear_busy}, 32'd1);
        for (int i = 0; i < 31; i++) tick();
        check_eq("coin_r31_c31", rd(31), 32'h5);
        check_eq("coin_r3_c31", rd(3), 32'h0);
        tick();
        check_eq("coin_r31_c32", rd(31), 32'h0);
        check_eq("coin_done", {31'b0, clear_done}, 32'd1);
        model_zero();

        // clear_req held through clear_done restarts a clear from IDLE
        clear_req = 1'b1;
        for (int i = 0; i < 33; i++) tick();
        check_eq("hold_done", {31'b0, clear_done}, 32'd1);
        check_eq("hold_busy_idle", {31'b0, clear_busy}, 32'd0);
        tick();
        clear_req = 1'b0;
        check_eq("hold_restart", {31'b0, clear_busy}, 32'd1);
        for (int i = 0; i < 31; i++) tick();
        check_eq("hold_busy_c31", {31'b0, clear_busy}, 32'd1);
        tick();
        check_eq("hold_done2", {31'b0, clear_done}, 32'd1);
        tick();

        // Reset at clear cycle 10 aborts the sequence
        do_write(5'd20, 32'h0000CAFE, 4'hF);
        do_write(5'd25, 32'h0000ABCD, 4'hF);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check_eq("abort_busy", {31'b0, clear_busy}, 32'd1);
        check_eq("abort_r20_pre", rd(20), 32'h0000CAFE);
        rst_n = 1'b0;
        #1;
        model_zero();
        check_eq("abort_busy_rst", {31'b0, clear_busy}, 32'd0);
        check_eq("abort_ready_rst", {31'b0, wr_ready}, 32'd1);
        check_eq("abort_regs_rst", {31'b0, |regs_out}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 34; i++) begin
            tick();
            check_eq($sformatf("abort_no_done%0d", i), {31'b0, clear_done}, 32'd0);
        end
        check_eq("abort_idle", {31'b0, state_dbg}, {31'b0, IDLE});
        do_write(5'd9, 32'h00000099, 4'hF);
        check_all("after_abort");

        // Reset in the cycle after an accepted write suppresses the ack
        wr_valid = 1'b1; wr_addr = 5'd4; wr_data = 32'h44; wr_be = 4'hF;
        tick();
        wr_valid = 1'b0;
        check_eq("sup_ack_pre", {31'b0, wr_ack}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("sup_ack_rst", {31'b0, wr_ack}, 32'd0);
        check_eq("sup_r4_rst", rd(4), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("sup_ack_after", {31'b0, wr_ack}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
